// File: rtl/mmio_bridge.sv
// mmio_bridge: memory-mapped I/O stage beside the data memory of the
// single-cycle core. It decodes a 4 KB window at IO_BASE and provides:
//   - a synchronized, debounced flap button with a sticky press flag,
//   - a free-running frame timer with a frame counter and frame flag,
//   - a graphics write FIFO drained by the video side over valid/ready.
//
// Ports:
//   clk, reset              : system clock, synchronous active-high reset
//   MemWrite, DataAdr,
//   WriteData               : core data-bus store strobe, byte address, data
//   ReadData                : combinational read data (0 outside the window)
//   io_sel                  : combinational window hit, steers the core's
//                             ReadData mux between this block and memory
//   btn_raw                 : asynchronous button input
//   gfx_valid, gfx_data,
//   gfx_ready               : FIFO output stream, first-word fall-through
//
// Handshake: a word moves on every rising edge where gfx_valid and gfx_ready
// are both 1. While gfx_valid=1 and gfx_ready=0, gfx_data holds its value;
// gfx_valid never drops without a transfer (except on reset).
//
// Register map (offset = DataAdr[11:0], DataAdr[1:0] ignored):
//   0x000 STATUS    R  [0] btn_level [1] press_flag [2] frame_flag
//                      [3] fifo_full [4] fifo_empty [5] overflow_flag
//   0x004 CLEAR     W  1 in bit 1/2/5 clears the matching flag
//   0x008 FRAME_CNT R  32-bit frame count
//   0x00C GFX_DATA  W  push WriteData into the FIFO
module mmio_bridge #(
  parameter logic [31:0] IO_BASE         = 32'h0000_F000,
  parameter int          FRAME_CYCLES    = 416800,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter int          FIFO_DEPTH      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        io_sel,
  input  logic        btn_raw,
  output logic        gfx_valid,
  output logic [31:0] gfx_data,
  input  logic        gfx_ready
);

  localparam int TW = $clog2(FRAME_CYCLES);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [TW-1:0] T_LAST  = TW'(FRAME_CYCLES - 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW:0]   DEPTH   = (PW + 1)'(FIFO_DEPTH);

  // Address decode
  logic [9:0] word;
  logic       wr, wr_clear, wr_gfx;
  logic       unused_addr_bits;

  assign io_sel   = (DataAdr[31:12] == IO_BASE[31:12]);
  assign word     = DataAdr[11:2];
  assign wr       = MemWrite & io_sel;
  assign wr_clear = wr & (word == 10'h001);
  assign wr_gfx   = wr & (word == 10'h003);
  assign unused_addr_bits = ^DataAdr[1:0];

  // State
  logic          sync1, sync2;
  logic [CW-1:0] db_cnt;
  logic          btn_level, press_flag, frame_flag, overflow_flag;
  logic [TW-1:0] timer;
  logic [31:0]   frame_cnt;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;

  // Derived strobes
  logic fifo_full, fifo_empty;
  logic btn_accept, press_set, frame_wrap;
  logic push, pop, ovf_set;

  assign fifo_full  = (count == DEPTH);
  assign fifo_empty = (count == '0);
  // A mismatch that has persisted for DEBOUNCE_CYCLES samples is accepted.
  assign btn_accept = (sync2 != btn_level) && (db_cnt == DB_LAST);
  assign press_set  = btn_accept & sync2;
  assign frame_wrap = (timer == T_LAST);
  // Fullness is judged on the current count, so a same-cycle pop does not
  // make room for a push that arrives while full.
  assign push       = wr_gfx & ~fifo_full;
  assign ovf_set    = wr_gfx & fifo_full;
  assign pop        = gfx_valid & gfx_ready;

  assign gfx_valid  = ~fifo_empty;
  assign gfx_data   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1         <= 1'b0;
      sync2         <= 1'b0;
      db_cnt        <= '0;
      btn_level     <= 1'b0;
      press_flag    <= 1'b0;
      frame_flag    <= 1'b0;
      overflow_flag <= 1'b0;
      timer         <= '0;
      frame_cnt     <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;

      if (sync2 == btn_level) begin
        db_cnt <= '0;
      end else if (btn_accept) begin
        db_cnt    <= '0;
        btn_level <= sync2;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end

      if (frame_wrap) begin
        timer     <= '0;
        frame_cnt <= frame_cnt + 32'd1;
      end else begin
        timer <= timer + 1'b1;
      end

      // Set has priority over a same-cycle CLEAR.
      press_flag    <= press_set  | (press_flag    & ~(wr_clear & WriteData[1]));
      frame_flag    <= frame_wrap | (frame_flag    & ~(wr_clear & WriteData[2]));
      overflow_flag <= ovf_set    | (overflow_flag & ~(wr_clear & WriteData[5]));

      if (push) begin
        mem[wr_ptr] <= WriteData;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Read mux; reads have no side effects.
  always_comb begin
    ReadData = '0;
    if (io_sel) begin
      case (word)
        10'h000: ReadData = {26'b0, overflow_flag, fifo_empty, fifo_full,
                             frame_flag, press_flag, btn_level};
        10'h002: ReadData = frame_cnt;
        default: ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed bench for mmio_bridge with FRAME_CYCLES=10, DEBOUNCE_CYCLES=16,
// FIFO_DEPTH=8. Inputs change 1 ns after the rising edge; outputs are read
// a further 1 ns later, well away from the active edge.
module tb_mmio_bridge;

  localparam logic [31:0] A_STATUS = 32'h0000_F000;
  localparam logic [31:0] A_CLEAR  = 32'h0000_F004;
  localparam logic [31:0] A_FCNT   = 32'h0000_F008;
  localparam logic [31:0] A_GFX    = 32'h0000_F00C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic        io_sel;
  logic        btn_raw = 1'b0;
  logic        gfx_valid;
  logic [31:0] gfx_data;
  logic        gfx_ready = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  mmio_bridge #(
    .IO_BASE(32'h0000_F000), .FRAME_CYCLES(10),
    .DEBOUNCE_CYCLES(16), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .ReadData(ReadData), .io_sel(io_sel),
    .btn_raw(btn_raw), .gfx_valid(gfx_valid), .gfx_data(gfx_data),
    .gfx_ready(gfx_ready)
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard check
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    MemWrite = 1'b0;
    steps(2);
    reset = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    MemWrite  = 1'b1;
    DataAdr   = addr;
    WriteData = data;
    step();
    MemWrite  = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    DataAdr = addr;
    #1;
    data = ReadData;
  endtask

  logic [31:0] st, v;

  initial begin
    // ---- reset state ----
    btn_raw = 1'b0;
    gfx_ready = 1'b0;
    reset = 1'b1;
    steps(2);
    rd(A_STATUS, st);   chk("rst_status", st, 32'h10);
    rd(A_FCNT, v);      chk("rst_frame_cnt", v, 32'h0);
    chk("rst_gfx_valid", 32'(gfx_valid), 32'h0);
    chk("rst_gfx_data", gfx_data, 32'h0);
    DataAdr = 32'h64; #1;
    chk("io_sel_low", 32'(io_sel), 32'h0);
    chk("rd_outside", ReadData, 32'h0);
    rd(32'h0000_F010, v); chk("rd_unmapped", v, 32'h0);
    rd(A_CLEAR, v);       chk("rd_clear", v, 32'h0);
    chk("io_sel_hit", 32'(io_sel), 32'h1);

    // ---- frame tick ----
    reset = 1'b0;
    steps(35);
    rd(A_FCNT, v);      chk("frame_cnt_35", v, 32'd3);
    rd(A_STATUS, st);   chk("frame_flag_set", 32'(st[2]), 32'h1);
    wr(A_CLEAR, 32'h4);                           // edge 36, no wrap
    rd(A_STATUS, st);   chk("frame_flag_clr", 32'(st[2]), 32'h0);
    steps(3);                                     // timer now at last count
    wr(A_CLEAR, 32'h4);                           // edge 40 is a wrap
    rd(A_STATUS, st);   chk("frame_set_wins", 32'(st[2]), 32'h1);
    rd(A_FCNT, v);      chk("frame_cnt_40", v, 32'd4);

    // ---- debounce ----
    do_reset();
    btn_raw = 1'b1;
    steps(17);
    rd(A_STATUS, st);   chk("btn_before_17", 32'(st[1:0]), 32'h0);
    step();
    rd(A_STATUS, st);   chk("btn_level_18", 32'(st[0]), 32'h1);
                        chk("press_flag_18", 32'(st[1]), 32'h1);
    steps(2);
    btn_raw = 1'b0;
    steps(5);
    btn_raw = 1'b1;
    steps(20);
    rd(A_STATUS, st);   chk("glitch_ignored", 32'(st[1:0]), 32'h3);
    wr(A_CLEAR, 32'h2);
    rd(A_STATUS, st);   chk("press_cleared", 32'(st[1:0]), 32'h1);
    btn_raw = 1'b0;
    steps(20);
    rd(A_STATUS, st);   chk("release_no_press", 32'(st[1:0]), 32'h0);

    // ---- FIFO fill and overflow ----
    do_reset();
    gfx_ready = 1'b0;
    chk("fifo_empty_valid", 32'(gfx_valid), 32'h0);
    wr(A_GFX, 32'h1);
    chk("push_latency_valid", 32'(gfx_valid), 32'h1);
    chk("push_latency_data", gfx_data, 32'h1);
    for (int i = 2; i <= 9; i++) wr(A_GFX, 32'(i));
    rd(A_STATUS, st);
    chk("fill_full", 32'(st[3]), 32'h1);
    chk("fill_empty", 32'(st[4]), 32'h0);
    chk("fill_overflow", 32'(st[5]), 32'h1);
    chk("hold_data", gfx_data, 32'h1);
    gfx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("drain_valid", 32'(gfx_valid), 32'h1);
      chk("drain_data", gfx_data, 32'(i));
      step();
    end
    chk("drained_valid", 32'(gfx_valid), 32'h0);
    rd(A_STATUS, st);   chk("drained_empty", 32'(st[4]), 32'h1);
    wr(A_CLEAR, 32'h20);
    rd(A_STATUS, st);   chk("ovf_cleared", 32'(st[5]), 32'h0);

    // push while full with a same-cycle pop: word dropped, overflow set
    gfx_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(A_GFX, 32'h11 + 32'(i));
    rd(A_STATUS, st);   chk("refill_status", st & 32'h38, 32'h08);
    gfx_ready = 1'b1;
    wr(A_GFX, 32'h99);
    rd(A_STATUS, st);
    chk("full_pop_ovf", 32'(st[5]), 32'h1);
    chk("full_pop_notfull", 32'(st[3]), 32'h0);
    for (int i = 2; i <= 8; i++) begin
      chk("drop_drain", gfx_data, 32'h10 + 32'(i));
      step();
    end
    chk("drop_drained", 32'(gfx_valid), 32'h0);

    // ---- concurrent push/pop ----
    do_reset();
    gfx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      MemWrite  = 1'b1;
      DataAdr   = A_GFX;
      WriteData = 32'hA0 + 32'(i);
      step();
      chk("stream_valid", 32'(gfx_valid), 32'h1);
      chk("stream_data", gfx_data, 32'hA0 + 32'(i));
      rd(A_STATUS, st);
      chk("stream_not_full", 32'(st[3]), 32'h0);
    end
    MemWrite = 1'b0;
    step();
    chk("stream_done_valid", 32'(gfx_valid), 32'h0);
    rd(A_STATUS, st);   chk("stream_no_ovf", 32'(st[5]), 32'h0);

    // ---- reset mid-stream ----
    gfx_ready = 1'b0;
    wr(A_GFX, 32'h1111);
    wr(A_GFX, 32'h2222);
    wr(A_GFX, 32'h3333);
    chk("queued_data", gfx_data, 32'h1111);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_valid", 32'(gfx_valid), 32'h0);
    chk("midrst_data", gfx_data, 32'h0);
    rd(A_STATUS, st);   chk("midrst_status", st, 32'h10);
    wr(A_GFX, 32'h55);
    chk("post_rst_valid", 32'(gfx_valid), 32'h1);
    chk("post_rst_data", gfx_data, 32'h55);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
